alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the pipelined CPU's EX stage. It keeps the existing 4-bit ALU control encoding, adds signed divide, remainder and high-half multiply, and makes the width configurable. Single-cycle operations finish in one clock; multiply (optionally) and divide/remainder run iteratively behind a start/busy/done handshake that the hazard unit uses to stall the pipeline.

---
 rtl/alu_mc.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_mc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle ops plus iterative
// signed mul/mulh and div/rem behind a start/busy/done handshake.
module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [3:0]       ALUCtrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             div0_o
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_SLLI = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_REM  = 4'b1101;
    localparam logic [3:0] OP_MULH = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [3:0]         op, op_n;
    logic               neg_q, neg_q_n;
    logic               neg_r, neg_r_n;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH-1:0]   mcand, mcand_n;
    logic [WIDTH-1:0]   quo, quo_n;
    logic [WIDTH-1:0]   rem, rem_n;
    logic [WIDTH-1:0]   dvsr, dvsr_n;
    logic [WIDTH-1:0]   data, data_n;
    logic               done, done_n;
    logic               div0, div0_n;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [SW-1:0]      shamt;
    logic               b_zero, is_ovf, accept;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   alu_res;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fin;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next, quo_next;
    logic [WIDTH-1:0]   quo_fin, rem_fin;

    assign sign_a = data1_i[WIDTH-1];
    assign sign_b = data2_i[WIDTH-1];
    assign mag_a  = sign_a ? -data1_i : data1_i;
    assign mag_b  = sign_b ? -data2_i : data2_i;
    assign shamt  = data2_i[SW-1:0];
    assign b_zero = (data2_i == '0);
    assign is_ovf = (data1_i == MIN_NEG) && (&data2_i);
    assign accept = start_i && (state == IDLE);

    // Full-width signed product for the combinational multiplier option.
    assign prod_c = {{WIDTH{sign_a}}, data1_i} * {{WIDTH{sign_b}}, data2_i};

    // One shift-add step: add |A| into the upper half when the
    // multiplier LSB is set, then shift the whole product right.
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]}
                    + (prod[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};
    assign mul_fin  = neg_q ? -mul_next : mul_next;

    // One restoring-division step on magnitudes.
    assign div_sh   = {rem, quo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, dvsr};
    assign div_ge   = ~div_diff[WIDTH];
    assign rem_next = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], div_ge};
    assign quo_fin  = neg_q ? -quo_next : quo_next;
    assign rem_fin  = neg_r ? -rem_next : rem_next;

    // Single-cycle result selection from the live operands.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND:  alu_res = data1_i & data2_i;
            OP_XOR:  alu_res = data1_i ^ data2_i;
            OP_OR:   alu_res = data1_i | data2_i;
            OP_SLL,
            OP_SLLI: alu_res = data1_i << shamt;
            OP_SRA:  alu_res = $signed(data1_i) >>> shamt;
            OP_ADD,
            OP_ADDI,
            OP_LW,
            OP_SW:   alu_res = data1_i + data2_i;
            OP_SUB:  alu_res = data1_i - data2_i;
            OP_MUL:  alu_res = prod_c[WIDTH-1:0];
            OP_MULH: alu_res = prod_c[2*WIDTH-1:WIDTH];
            default: alu_res = '0;
        endcase
    end

    // Next-state and datapath updates for the IDLE/MUL/DIV machine.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op;
        neg_q_n = neg_q;
        neg_r_n = neg_r;
        prod_n  = prod;
        mcand_n = mcand;
        quo_n   = quo;
        rem_n   = rem;
        dvsr_n  = dvsr;
        data_n  = data;
        done_n  = 1'b0;
        div0_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_n  = ALUCtrl_i;
                    cnt_n = '0;
                    if ((ALUCtrl_i == OP_MUL || ALUCtrl_i == OP_MULH)
                        && MUL_ITER != 0) begin
                        state_n = MUL;
                        prod_n  = {{WIDTH{1'b0}}, mag_b};
                        mcand_n = mag_a;
                        neg_q_n = sign_a ^ sign_b;
                    end else if (ALUCtrl_i == OP_DIV
                                 || ALUCtrl_i == OP_REM) begin
                        if (b_zero) begin
                            done_n = 1'b1;
                            div0_n = 1'b1;
                            data_n = (ALUCtrl_i == OP_DIV) ? '1 : data1_i;
                        end else if (is_ovf) begin
                            done_n = 1'b1;
                            data_n = (ALUCtrl_i == OP_DIV) ? data1_i : '0;
                        end else begin
                            state_n = DIV;
                            quo_n   = mag_a;
                            rem_n   = '0;
                            dvsr_n  = mag_b;
                            neg_q_n = sign_a ^ sign_b;
                            neg_r_n = sign_a;
                        end
                    end else begin
                        done_n = 1'b1;
                        data_n = alu_res;
                    end
                end
            end
            MUL: begin
                prod_n = mul_next;
                cnt_n  = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    data_n  = (op == OP_MULH)
                            ? mul_fin[2*WIDTH-1:WIDTH]
                            : mul_fin[WIDTH-1:0];
                end
            end
            DIV: begin
                quo_n = quo_next;
                rem_n = rem_next;
                cnt_n = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    data_n  = (op == OP_DIV) ? quo_fin : rem_fin;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; reset aborts any operation and clears the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            prod  <= '0;
            mcand <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            data  <= '0;
            done  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op    <= op_n;
            neg_q <= neg_q_n;
            neg_r <= neg_r_n;
            prod  <= prod_n;
            mcand <= mcand_n;
            quo   <= quo_n;
            rem   <= rem_n;
            dvsr  <= dvsr_n;
            data  <= data_n;
            done  <= done_n;
            div0  <= div0_n;
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = done;
    assign data_o = data;
    assign div0_o = div0;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: iterative and combinational
// multiplier instances, handshake, corner cases and reset.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start_c;
    logic [W-1:0] d1, d2;
    logic [3:0]   ctrl;
    logic         busy, done, div0;
    logic [W-1:0] data;
    logic         busy_c, done_c, div0_c;
    logic [W-1:0] data_c;

    int errs = 0;
    int checks = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .MUL_ITER(1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .data1_i(d1), .data2_i(d2), .ALUCtrl_i(ctrl),
        .busy_o(busy), .done_o(done), .data_o(data), .div0_o(div0)
    );

    alu_mc #(.WIDTH(W), .MUL_ITER(0)) dut_c (
        .clk_i(clk), .rst_i(rst), .start_i(start_c),
        .data1_i(d1), .data2_i(d2), .ALUCtrl_i(ctrl),
        .busy_o(busy_c), .done_o(done_c), .data_o(data_c), .div0_o(div0_c)
    );

    always @(negedge clk) if (done) done_pulses++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input bit comb,
                       input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp,
                       input logic exp_d0, input int exp_lat);
        int lat;
        int bcnt;
        @(negedge clk);
        ctrl = op; d1 = a; d2 = b;
        if (comb) start_c = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_c = 1'b0;
        lat = 0; bcnt = 0;
        while (!(comb ? done_c : done) && lat < 100) begin
            if (comb ? busy_c : busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busycyc"}, bcnt, exp_lat);
        chk({tag, "_data"}, comb ? data_c : data, exp);
        chk({tag, "_div0"}, comb ? div0_c : div0, exp_d0);
        chk({tag, "_busy_at_done"}, comb ? busy_c : busy, 0);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, comb ? done_c : done, 0);
    endtask

    initial begin
        int lat;
        int snap;
        rst = 1'b1; start = 1'b0; start_c = 1'b0;
        d1 = '0; d2 = '0; ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data, 0);
        chk("rst_div0", div0, 0);
        rst = 1'b0;

        run("add", 0, 4'b0011, 32'd7, -32'sd3, 32'd4, 0, 0);
        run("sub", 0, 4'b0100, 32'd5, 32'd9, 32'hFFFFFFFC, 0, 0);
        run("sra", 0, 4'b0111, 32'h80000000, 32'd4, 32'hF8000000, 0, 0);
        run("sll", 0, 4'b0010, 32'd1, 32'h21, 32'd2, 0, 0);
        run("op15", 0, 4'b1111, 32'd123, 32'd45, 32'd0, 0, 0);
        run("or", 0, 4'b1011, 32'hF0, 32'h0F, 32'hFF, 0, 0);
        run("xor", 0, 4'b0001, 32'hFF00, 32'h0FF0, 32'hF0F0, 0, 0);

        run("mul", 0, 4'b0101, -32'sd6, 32'd7, 32'hFFFFFFD6, 0, 32);
        run("mulh", 0, 4'b1110, 32'h40000000, 32'd4, 32'd1, 0, 32);
        run("mulh_neg", 0, 4'b1110, 32'hFFFFFFFF, 32'd1,
            32'hFFFFFFFF, 0, 32);
        run("mul_comb", 1, 4'b0101, -32'sd6, 32'd7, 32'hFFFFFFD6, 0, 0);

        run("div", 0, 4'b1100, -32'sd7, 32'd2, 32'hFFFFFFFD, 0, 32);
        run("rem", 0, 4'b1101, -32'sd7, 32'd2, 32'hFFFFFFFF, 0, 32);
        run("rem_pos", 0, 4'b1101, 32'd7, -32'sd2, 32'd1, 0, 32);
        run("div100", 0, 4'b1100, 32'd100, 32'd7, 32'd14, 0, 32);
        run("div0", 0, 4'b1100, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
        run("rem0", 0, 4'b1101, 32'd5, 32'd0, 32'd5, 1, 0);
        run("div_ovf", 0, 4'b1100, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 0, 0);
        run("rem_ovf", 0, 4'b1101, 32'h80000000, 32'hFFFFFFFF,
            32'd0, 0, 0);

        // start held high through a div, operands changed after E0,
        // then a back-to-back add issued in the done cycle
        @(negedge clk);
        ctrl = 4'b1100; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        ctrl = 4'b0011; d1 = 32'd1; d2 = 32'd1;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_lat", lat, 32);
        chk("hold_data", data, 32'd14);
        chk("hold_busy_at_done", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done", done, 1);
        chk("b2b_data", data, 32'd2);
        @(posedge clk); #1;
        chk("b2b_done_1cyc", done, 0);

        // reset in the middle of a div
        @(negedge clk);
        ctrl = 4'b1100; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        snap = done_pulses;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data, 0);
        chk("midrst_done", done, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_done", done_pulses, snap);
        run("after_rst", 0, 4'b0011, 32'd20, 32'd22, 32'd42, 0, 0);

        // reset and start in the same cycle: request is lost
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        ctrl = 4'b0011; d1 = 32'd2; d2 = 32'd3;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rststart_done", done, 0);
        @(posedge clk); #1;
        chk("rststart_done2", done, 0);
        chk("rststart_busy", busy, 0);
        chk("rststart_data", data, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
